// File: rtl/handshake_rx_fifo.sv
// handshake_rx_fifo
// Receiver for the pin-level 4-phase req/ack handshake. Each handshake is either
// pushed into a DEPTH-entry FIFO as {is_key, data} or, for reset-hash commands,
// turned into a one-cycle reset_hash_pulse without touching the FIFO. Entries are
// drained to the data router as one-cycle out_pulse strobes while drain_en is high.
//
// Build option: define HS_RX_SYNC_EN to pass req_i through a SYNC_STAGES-flop
// synchroniser. Leave it undefined when req_i is already synchronous to clk.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_REARM | after reset; wait for req low so a stale request is not taken
// S_IDLE  | waiting for req high; capture or stall when the FIFO is full
// S_ACK   | command taken, ack_o high; wait for req low
module handshake_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       is_key_i,
    input  logic                       reset_hash_i,
    output logic                       ack_o,
    input  logic                       drain_en,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_is_key,
    output logic                       out_pulse,
    output logic                       reset_hash_pulse,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef HS_RX_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_REARM = 2'd0,
        S_IDLE  = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_req_s;
    logic                  w_sync_ok;
    logic                  w_push;
    logic                  w_hash;
    logic                  w_pop;
    logic                  w_full;

    logic [DATA_W:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ack;
    logic                  r_hash_pulse;
    logic                  r_out_pulse;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_out_is_key;

    // The synchroniser flops reset to 0, which would look like a valid "req low"
    // right after reset. r_prime marks when req_s reflects a real post-reset sample
    // so a request held high across reset cannot slip through S_REARM.
    generate
        if (SYNC_EN) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            logic [SYNC_STAGES-1:0] r_prime;

            // Request synchroniser and its fill marker.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync  <= '0;
                    r_prime <= '0;
                end else begin
                    r_sync  <= {r_sync[SYNC_STAGES-2:0], req_i};
                    r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
                end
            end

            assign w_req_s   = r_sync[SYNC_STAGES-1];
            assign w_sync_ok = r_prime[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_req_s   = req_i;
            assign w_sync_ok = 1'b1;
        end
    endgenerate

    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = drain_en && (r_count != '0);

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; push/hash fire only on the IDLE->ACK transition, so one
    // handshake yields at most one capture.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_hash      = 1'b0;
        case (r_state)
            S_REARM: begin
                if (w_sync_ok && !w_req_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_req_s) begin
                    if (reset_hash_i) begin
                        w_hash      = 1'b1;
                        w_state_nxt = S_ACK;
                    end else if (!w_full) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!w_req_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_REARM;
            end
        endcase
    end

    // Registered handshake outputs: ack tracks the ACK state, hash pulse is one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack        <= 1'b0;
            r_hash_pulse <= 1'b0;
        end else begin
            r_ack        <= (w_state_nxt == S_ACK);
            r_hash_pulse <= w_hash;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {is_key_i, data_i};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain port: head entry presented for exactly one cycle per pop, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_pulse  <= 1'b0;
            r_out_data   <= '0;
            r_out_is_key <= 1'b0;
        end else begin
            r_out_pulse <= w_pop;
            if (w_pop) begin
                r_out_data   <= r_mem[r_rd_ptr][DATA_W-1:0];
                r_out_is_key <= r_mem[r_rd_ptr][DATA_W];
            end else begin
                r_out_data   <= '0;
                r_out_is_key <= 1'b0;
            end
        end
    end

    assign ack_o            = r_ack;
    assign reset_hash_pulse = r_hash_pulse;
    assign out_pulse        = r_out_pulse;
    assign out_data         = r_out_data;
    assign out_is_key       = r_out_is_key;
    assign fifo_count       = r_count;
    assign full             = w_full;

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Testbench for handshake_rx_fifo: directed scenarios plus randomized handshakes
// and drain activity, checked every cycle against a queue-based reference model.
module tb_handshake_rx_fifo;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
`ifdef HS_RX_SYNC_EN
    localparam int S = SYNC_STAGES;
`else
    localparam int S = 0;
`endif
    localparam int LAT = S + 1;

    logic                       clk;
    logic                       rst;
    logic                       req_i;
    logic [DATA_W-1:0]          data_i;
    logic                       is_key_i;
    logic                       reset_hash_i;
    logic                       ack_o;
    logic                       drain_en;
    logic [DATA_W-1:0]          out_data;
    logic                       out_is_key;
    logic                       out_pulse;
    logic                       reset_hash_pulse;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       full;

    handshake_rx_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req_i),
        .data_i           (data_i),
        .is_key_i         (is_key_i),
        .reset_hash_i     (reset_hash_i),
        .ack_o            (ack_o),
        .drain_en         (drain_en),
        .out_data         (out_data),
        .out_is_key       (out_is_key),
        .out_pulse        (out_pulse),
        .reset_hash_pulse (reset_hash_pulse),
        .fifo_count       (fifo_count),
        .full             (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected FIFO contents plus handshake bookkeeping.
    logic [DATA_W:0] mq[$];
    logic            hist [0:7];
    int              edges_since_rst;
    bit              served;
    bit              armed;
    bit              rnd_drain;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        edges_since_rst = 0;
        served = 1'b0;
        armed  = 1'b0;
    endtask

    // One clock: predict the edge from the inputs, then compare all outputs.
    task automatic step();
        int              cnt_before;
        logic            req_s_m;
        logic            e_pulse;
        logic            e_rh;
        logic [DATA_W:0] e_word;
        @(posedge clk);
        edges_since_rst++;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = req_i;
        req_s_m = hist[S];
        cnt_before = mq.size();
        e_pulse = 1'b0;
        e_rh    = 1'b0;
        e_word  = '0;
        if (drain_en && cnt_before > 0) begin
            e_pulse = 1'b1;
            e_word  = mq.pop_front();
        end
        if (edges_since_rst > S) begin
            if (req_s_m) begin
                if (armed && !served) begin
                    if (reset_hash_i) begin
                        e_rh   = 1'b1;
                        served = 1'b1;
                    end else if (cnt_before < DEPTH) begin
                        mq.push_back({is_key_i, data_i});
                        served = 1'b1;
                    end
                end
            end else begin
                served = 1'b0;
                armed  = 1'b1;
            end
        end
        #1;
        chk("ack_o", ack_o, served);
        chk("out_pulse", out_pulse, e_pulse);
        chk("out_data", out_data, e_word[DATA_W-1:0]);
        chk("out_is_key", out_is_key, e_word[DATA_W]);
        chk("reset_hash_pulse", reset_hash_pulse, e_rh);
        chk("fifo_count", fifo_count, mq.size());
        chk("full", full, (mq.size() == DEPTH));
        if (rnd_drain) drain_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output int n);
        n = 0;
        while (ack_o !== lvl && n < budget) begin
            step();
            n++;
        end
        if (ack_o !== lvl) chk("ack_timeout", ack_o, lvl);
    endtask

    task automatic req_up(input logic [DATA_W-1:0] d, input logic k, input logic rh);
        data_i       = d;
        is_key_i     = k;
        reset_hash_i = rh;
        req_i        = 1'b1;
    endtask

    task automatic hs(input logic [DATA_W-1:0] d, input logic k, input logic rh);
        int n;
        req_up(d, k, rh);
        wait_ack(1'b1, 300, n);
        req_i = 1'b0;
        wait_ack(1'b0, 300, n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_i = 1'b0;
        data_i = '0;
        is_key_i = 1'b0;
        reset_hash_i = 1'b0;
        drain_en = 1'b0;
        rnd_drain = 1'b0;
        model_reset();
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_pulse", out_pulse, 0);
        chk("rst_count", fifo_count, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (S + 2) step();

        // Single write with exact latency, then drain it.
        req_up(8'hA5, 1'b1, 1'b0);
        wait_ack(1'b1, 20, n);
        chk("t1_latency", n, LAT);
        chk("t1_count", fifo_count, 1);
        req_i = 1'b0;
        wait_ack(1'b0, 20, n);
        chk("t1_ack_fall", n, LAT);
        drain_en = 1'b1;
        step();
        chk("t1_data", out_data, 8'hA5);
        drain_en = 1'b0;
        step();

        // Fill, stall on the fifth, free one slot, then drain the rest.
        hs(8'h11, 1'b0, 1'b0);
        hs(8'h22, 1'b0, 1'b0);
        hs(8'h33, 1'b1, 1'b0);
        hs(8'h44, 1'b0, 1'b0);
        chk("t2_full", full, 1);
        req_up(8'h55, 1'b0, 1'b0);
        repeat (LAT + 4) step();
        chk("t2_stall", ack_o, 0);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        wait_ack(1'b1, 20, n);
        chk("t2_count", fifo_count, 4);
        req_i = 1'b0;
        wait_ack(1'b0, 20, n);
        drain_en = 1'b1;
        repeat (6) step();
        drain_en = 1'b0;
        step();

        // Reset-hash while full: FIFO must be left alone.
        for (int i = 0; i < DEPTH; i++) hs(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        hs(8'hFF, 1'b0, 1'b1);
        chk("t3_count", fifo_count, 4);
        drain_en = 1'b1;
        repeat (6) step();
        drain_en = 1'b0;

        // Concurrent push and pop with two entries waiting.
        hs(8'h61, 1'b0, 1'b0);
        hs(8'h62, 1'b1, 1'b0);
        drain_en = 1'b1;
        hs(8'h63, 1'b0, 1'b0);
        hs(8'h64, 1'b1, 1'b0);
        repeat (4) step();
        drain_en = 1'b0;
        step();

        // Randomized handshakes against random drain activity.
        rnd_drain = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            hs(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        rnd_drain = 1'b0;
        drain_en = 1'b1;
        repeat (6) step();
        drain_en = 1'b0;
        step();

        // Reset in the middle of an acknowledged handshake with req held high.
        hs(8'h71, 1'b0, 1'b0);
        req_up(8'h72, 1'b1, 1'b0);
        wait_ack(1'b1, 20, n);
        rst = 1'b1;
        #1;
        chk("t5_ack_async", ack_o, 0);
        chk("t5_count", fifo_count, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (LAT + 5) step();
        chk("t5_no_stale", ack_o, 0);
        req_i = 1'b0;
        repeat (LAT + 2) step();
        hs(8'h81, 1'b1, 1'b0);
        chk("t5_accept", fifo_count, 1);
        drain_en = 1'b1;
        repeat (2) step();
        drain_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
